// File: rtl/vram_ctrl_pkg.sv
// vram_ctrl_pkg: shared constants, state type and helpers for the glyph region scheduler
package vram_ctrl_pkg;
  localparam int ROWS = 523;
  localparam int WIDTH = 150;
  localparam int NREG = 4;
  localparam int ROW_W = $clog2(ROWS);
  typedef enum logic [0:0] {IDLE, COPY} sched_state_t;
  typedef logic [3:0] glyph_t;
  function automatic logic [1:0] lowestSet(input logic [3:0] v);
    lowestSet = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) lowestSet = 2'(i);
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer, stable-sample counter and one-cycle press pulse on a debounced 1->0
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn,
  output logic Press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, level;
  logic [CW-1:0] count;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      count <= '0;
      Press <= 1'b0;
    end else begin
      sync1 <= Btn;
      sync2 <= sync1;
      Press <= 1'b0;
      if (sync2 == level) count <= '0;
      else if (count == LAST) begin
        level <= sync2;
        count <= '0;
        Press <= level;
      end else count <= count + CW'(1);
    end
endmodule

// File: rtl/glyph_region_scheduler.sv
// glyph_region_scheduler: button-driven glyph selection and vblank-gated glyph ROM to region RAM copies
module glyph_region_scheduler #(
  parameter int ROWS = vram_ctrl_pkg::ROWS,
  parameter int WIDTH = vram_ctrl_pkg::WIDTH,
  parameter int NREG = vram_ctrl_pkg::NREG,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnRegion,
  input  logic BtnLetra,
  input  logic VBlank,
  output logic [3:0] RomGlyph,
  output logic [$clog2(ROWS)-1:0] RomRow,
  input  logic [WIDTH-1:0] RomData,
  output logic WrEn,
  output logic [1:0] WrRegion,
  output logic [$clog2(ROWS)-1:0] WrRow,
  output logic [WIDTH-1:0] WrData,
  output logic [1:0] SelRegion,
  output logic [4*NREG-1:0] GlyphCodes,
  output logic Busy
);
  import vram_ctrl_pkg::sched_state_t;
  import vram_ctrl_pkg::glyph_t;
  import vram_ctrl_pkg::lowestSet;
  import vram_ctrl_pkg::IDLE;
  import vram_ctrl_pkg::COPY;
  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(ROWS + 1);
  localparam logic [KW-1:0] LAST = KW'(ROWS);
  sched_state_t state;
  logic [KW-1:0] k;
  logic [NREG-1:0] dirty, dirtyNext;
  glyph_t glyphs [NREG];
  logic regionPress, letraPress, start;
  logic [1:0] pick;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) regionDb (
    .Clk(Clk), .Reset(Reset), .Btn(BtnRegion), .Press(regionPress)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) letraDb (
    .Clk(Clk), .Reset(Reset), .Btn(BtnLetra), .Press(letraPress)
  );
  for (genvar i = 0; i < NREG; i++) begin : g_codes
    assign GlyphCodes[4*i +: 4] = glyphs[i];
  end
  assign WrData = RomData;
  assign Busy = (state == COPY) | (|dirty);
  // a press landing on the region being started wins, so it gets recopied
  always_comb begin
    pick = lowestSet(4'(dirty));
    start = VBlank && (|dirty) && (state == IDLE || k == LAST);
    dirtyNext = (dirty & ~(start ? NREG'(1) << pick : '0)) | (letraPress ? NREG'(1) << SelRegion : '0);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      k <= '0;
      dirty <= '1;
      SelRegion <= '0;
      for (int i = 0; i < NREG; i++) glyphs[i] <= glyph_t'(i);
      RomGlyph <= '0;
      RomRow <= '0;
      WrEn <= 1'b0;
      WrRegion <= '0;
      WrRow <= '0;
    end else begin
      SelRegion <= SelRegion + 2'(regionPress);
      if (letraPress) glyphs[SelRegion] <= glyphs[SelRegion] + glyph_t'(1);
      dirty <= dirtyNext;
      if (start) begin
        state <= COPY;
        k <= '0;
        WrRegion <= pick;
        RomGlyph <= glyphs[pick];
        RomRow <= '0;
        WrEn <= 1'b0;
      end else if (state == COPY && k == LAST) begin
        state <= IDLE;
        WrEn <= 1'b0;
      end else if (state == COPY) begin
        // ROM data for row k-1 arrives now, so the write trails the address by one cycle
        WrEn <= 1'b1;
        WrRow <= RW'(k);
        k <= k + KW'(1);
        if (k < LAST - KW'(1)) RomRow <= RomRow + RW'(1);
      end
    end
endmodule

// File: doc/glyph_region_scheduler.md
Name: glyph_region_scheduler

Overview:
- Sequences the four-region character display: debounces the Region/Letra push-buttons, tracks the selected region and a 4-bit hex glyph code per region.
- Copies the chosen glyph bitmap, row by row, from the glyph ROM into the selected region's framebuffer.
- Copies start only during vertical blanking.
- Sits between the board buttons, the glyph ROM, the four region RAMs and the VGA timing generator.

Parameters:
- ROWS, 523, bitmap rows per region (equals vertical total).
- WIDTH, 150, pixels per bitmap row (region width).
- NREG, 4, number of screen regions.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a button level (10 ms at 25 MHz).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- BtnRegion  in  1  raw button, active-low; a press advances the selected region.
- BtnLetra  in  1  raw button, active-low; a press advances the glyph of the selected region.
- VBlank  in  1  high during vertical blanking.
- RomGlyph  out  4  glyph ROM address, high part.
- RomRow  out  $clog2(ROWS)  glyph ROM address, row part.
- RomData  in  WIDTH  ROM row data; 1-cycle read latency.
- WrEn  out  1  region RAM write strobe.
- WrRegion  out  2  target region.
- WrRow  out  $clog2(ROWS)  target row.
- WrData  out  WIDTH  row data, equal to RomData.
- SelRegion  out  2  currently selected region.
- GlyphCodes  out  4*NREG  glyph code of region i in bits [4i+3:4i].
- Busy  out  1  high while a copy is in progress or any region is dirty.

Behaviour:
- Reset (asynchronous, any state, including mid-copy):
  - Copy aborts immediately; WrEn=0, RomGlyph=0, RomRow=0, WrRegion=0, WrRow=0.
  - SelRegion=0, GlyphCodes={4'd3,4'd2,4'd1,4'd0}, dirty=4'b1111.
  - Debounced button levels=1; state=IDLE.
  - Busy=1 on the first cycle after reset release, because dirty is nonzero.
- Button input path:
  - 2-FF synchronizer, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - A press event is a one-cycle pulse on a debounced 1->0 transition.
- Region press: SelRegion <= SelRegion+1, wrapping 3->0.
- Letra press: glyph[SelRegion] <= glyph+1, wrapping F->0, and dirty[SelRegion] <= 1.
- Both presses in the same cycle: the glyph increment and dirty bit apply to the old SelRegion; the region advances in the same cycle.
- A press during a copy is accepted normally. If it hits the region being copied, dirty is re-set, so the region is recopied afterwards. The current copy uses the glyph latched at its start.
- FSM states:
  - IDLE: if VBlank=1 and dirty!=0, pick the lowest-index dirty region r, clear dirty[r], latch G=glyph[r], reset row counter k=0, go to COPY. Otherwise stay.
  - COPY, cycle k for k=0..ROWS-1: RomGlyph=G, RomRow=k.
  - COPY, cycles k=1..ROWS: WrEn=1, WrRegion=r, WrRow=k-1, WrData=RomData.
  - COPY lasts ROWS+1 cycles, then returns to IDLE. Back-to-back copies are allowed when VBlank is still high.
- VBlank falling during COPY does not abort the copy; it completes.
- WrEn is never asserted outside COPY. WrRow never exceeds ROWS-1.
- Busy = (state==COPY) | (|dirty).

Decomposition:
- Package vram_ctrl_pkg holds:
  - constants ROWS, WIDTH, NREG, ROW_W=$clog2(ROWS);
  - typedef enum logic [0:0] {IDLE, COPY} sched_state_t;
  - typedef logic [3:0] glyph_t.
- Sub-module button_debouncer (synchronizer + counter + falling-edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated twice.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and ROWS=8.
- Reset release with VBlank=1 held: four back-to-back copies, regions 0,1,2,3 with RomGlyph 0,1,2,3. Each has 8 WrEn pulses, WrRow 0..7, 9 cycles per copy; Busy falls after 36 cycles.
- VBlank=0, BtnLetra held low 3 cycles then released: no event, GlyphCodes unchanged. Held low 6 cycles: glyph0 becomes 1 and dirty[0] set. No WrEn until VBlank rises; the copy then uses RomGlyph=1.
- 16 Letra presses on region 0: glyph0 wraps F->0. 5 Region presses: SelRegion sequence 1,2,3,0,1.
- Region and Letra debounced pulses in the same cycle with SelRegion=2: glyph2 increments, dirty[2]=1, SelRegion=3.
- Letra press on region 1 at copy row 4 of region 1: copy completes with the old glyph, then region 1 is recopied with the new glyph.
- Reset asserted mid-copy at row 3: WrEn drops the same cycle (asynchronous). After release, GlyphCodes=0x3210 and all four regions are recopied.
